dual_issue_scheduler: RTL and testbench

- Issue controller between the dual-fetch decode pair register and the execute stage of the superscalar core.
- Each cycle it decides whether the fetched instruction pair issues together, issues split over two cycles, or stalls.
- Decisions are based on intra-pair hazards, single data-memory-port contention, control transfers, and a load-latency scoreboard.
- It provides the handshake the front end uses to advance fetch and exports performance counters.

---
 rtl/mips_issue_pkg.sv | 33 +++
 rtl/issue_decode.sv | 52 +++++
 rtl/dual_issue_scheduler.sv | 151 +++++++++++++++
 tb/tb_dual_issue_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_issue_pkg.sv
// Shared types for the dual-issue scheduler: opcodes, decoded-slot record, FSM states.
package mips_issue_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // has_* flags are already cleared for r0 so hazard logic never has to test for it
   typedef struct packed {
      logic [4:0] src_a;
      logic [4:0] src_b;
      logic [4:0] dst;
      logic       has_a;
      logic       has_b;
      logic       has_dst;
      logic       is_mem;
      logic       is_load;
      logic       is_ctrl;
   } dec_instr_t;

   typedef enum logic {S_PAIR, S_SECOND} state_t;

endpackage

// File: rtl/issue_decode.sv
// Per-slot decoder: classifies one instruction into register usage and issue constraints.
module issue_decode
   import mips_issue_pkg::*;
(
   input  logic [31:0] i_instr,
   output dec_instr_t  o_dec
);

   logic [5:0] w_op;
   logic [4:0] w_rs, w_rt, w_rd;
   logic       w_use_a, w_use_b, w_use_d;
   logic [4:0] w_dst;
   logic       w_unused_bits;

   assign w_op          = i_instr[31:26];
   assign w_rs          = i_instr[25:21];
   assign w_rt          = i_instr[20:16];
   assign w_rd          = i_instr[15:11];
   assign w_unused_bits = ^i_instr[10:0];

   // opcode class lookup; unknown opcodes are forced single issue
   always_comb begin
      w_use_a = 1'b0;
      w_use_b = 1'b0;
      w_use_d = 1'b0;
      w_dst   = 5'd0;
      o_dec   = '0;
      case (w_op)
         OP_RTYPE: begin w_use_a = 1'b1; w_use_b = 1'b1; w_use_d = 1'b1; w_dst = w_rd; end
         OP_LW: begin
            w_use_a = 1'b1; w_use_d = 1'b1; w_dst = w_rt;
            o_dec.is_mem = 1'b1; o_dec.is_load = 1'b1;
         end
         OP_SW: begin w_use_a = 1'b1; w_use_b = 1'b1; o_dec.is_mem = 1'b1; end
         OP_BEQ, OP_BNE: begin w_use_a = 1'b1; w_use_b = 1'b1; o_dec.is_ctrl = 1'b1; end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: begin
            w_use_a = 1'b1; w_use_d = 1'b1; w_dst = w_rt;
         end
         OP_LUI: begin w_use_d = 1'b1; w_dst = w_rt; end
         OP_J:   o_dec.is_ctrl = 1'b1;
         OP_JAL: begin w_use_d = 1'b1; w_dst = 5'd31; o_dec.is_ctrl = 1'b1; end
         default: o_dec.is_ctrl = 1'b1;
      endcase
      o_dec.src_a   = w_rs;
      o_dec.src_b   = w_rt;
      o_dec.dst     = w_dst;
      o_dec.has_a   = w_use_a & (w_rs != 5'd0);
      o_dec.has_b   = w_use_b & (w_rt != 5'd0);
      o_dec.has_dst = w_use_d & (w_dst != 5'd0);
   end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Issue controller for the fetched instruction pair: pair / split / stall decision,
// load-latency scoreboard and stall/split performance counters.
//
// state    | meaning
// S_PAIR   | fresh pair: issue both, slot0 only, or stall
// S_SECOND | slot0 already issued, slot1 pending on lane0
module dual_issue_scheduler
   import mips_issue_pkg::*;
#(
   parameter int LOAD_LAT = 2,
   parameter int NREGS    = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_instr0,
   input  logic [31:0] in_instr1,
   output logic        in_ready,
   input  logic        ex_ready,
   input  logic        flush,
   output logic        iss0_valid,
   output logic [31:0] iss0_instr,
   output logic [31:0] iss0_pc,
   output logic        iss1_valid,
   output logic [31:0] iss1_instr,
   output logic [31:0] iss1_pc,
   output logic [31:0] stall_cnt,
   output logic [31:0] split_cnt
);

   dec_instr_t  w_d0, w_d1;
   state_t      r_state, w_state_nxt;
   logic [2:0]  r_sb [NREGS];
   logic [31:0] r_stall_cnt, r_split_cnt;
   logic        w_blk0, w_blk1, w_raw, w_waw, w_pair_ok;
   logic        w_stall, w_split, w_ld_issue;
   logic [4:0]  w_ld_reg;
   logic        w_unused_ctrl1;

   issue_decode u_dec0 (.i_instr(in_instr0), .o_dec(w_d0));
   issue_decode u_dec1 (.i_instr(in_instr1), .o_dec(w_d1));

   // a slot1 control transfer may still pair; only slot0 control forces a split
   assign w_unused_ctrl1 = w_d1.is_ctrl;

   assign w_blk0 = (w_d0.has_a && (r_sb[w_d0.src_a] != 3'd0)) ||
                   (w_d0.has_b && (r_sb[w_d0.src_b] != 3'd0));
   assign w_blk1 = (w_d1.has_a && (r_sb[w_d1.src_a] != 3'd0)) ||
                   (w_d1.has_b && (r_sb[w_d1.src_b] != 3'd0));
   assign w_raw  = w_d0.has_dst &&
                   ((w_d1.has_a && (w_d1.src_a == w_d0.dst)) ||
                    (w_d1.has_b && (w_d1.src_b == w_d0.dst)));
   assign w_waw  = w_d0.has_dst && w_d1.has_dst && (w_d1.dst == w_d0.dst);
   assign w_pair_ok = !w_raw && !w_waw && !(w_d0.is_mem && w_d1.is_mem) &&
                      !w_d0.is_ctrl && !w_blk0 && !w_blk1;

   assign stall_cnt = r_stall_cnt;
   assign split_cnt = r_split_cnt;

   // next-state and issue decision; reset and flush suppress every issue
   always_comb begin
      w_state_nxt = r_state;
      iss0_valid  = 1'b0;
      iss0_instr  = 32'd0;
      iss0_pc     = 32'd0;
      iss1_valid  = 1'b0;
      iss1_instr  = 32'd0;
      iss1_pc     = 32'd0;
      in_ready    = 1'b0;
      w_stall     = 1'b0;
      w_split     = 1'b0;
      w_ld_issue  = 1'b0;
      w_ld_reg    = 5'd0;
      if (reset) begin
         w_state_nxt = S_PAIR;
      end else if (flush) begin
         w_state_nxt = S_PAIR;
      end else if (ex_ready) begin
         case (r_state)
            S_PAIR: begin
               if (in_valid) begin
                  if (w_blk0) begin
                     w_stall = 1'b1;
                  end else begin
                     iss0_valid = 1'b1;
                     iss0_instr = in_instr0;
                     iss0_pc    = in_pc;
                     w_ld_issue = w_d0.is_load && w_d0.has_dst;
                     w_ld_reg   = w_d0.dst;
                     if (w_pair_ok) begin
                        iss1_valid = 1'b1;
                        iss1_instr = in_instr1;
                        iss1_pc    = in_pc + 32'd4;
                        in_ready   = 1'b1;
                        if (w_d1.is_load && w_d1.has_dst) begin
                           w_ld_issue = 1'b1;
                           w_ld_reg   = w_d1.dst;
                        end
                     end else begin
                        w_state_nxt = S_SECOND;
                     end
                  end
               end
            end
            S_SECOND: begin
               if (w_blk1) begin
                  w_stall = 1'b1;
               end else begin
                  iss0_valid  = 1'b1;
                  iss0_instr  = in_instr1;
                  iss0_pc     = in_pc + 32'd4;
                  in_ready    = 1'b1;
                  w_split     = 1'b1;
                  w_ld_issue  = w_d1.is_load && w_d1.has_dst;
                  w_ld_reg    = w_d1.dst;
                  w_state_nxt = S_PAIR;
               end
            end
            default: w_state_nxt = S_PAIR;
         endcase
      end
   end

   // state register and wrapping performance counters
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_PAIR;
         r_stall_cnt <= 32'd0;
         r_split_cnt <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_split) r_split_cnt <= r_split_cnt + 32'd1;
      end
   end

   // scoreboard: a new load reloads the counter, otherwise count down to zero (also during flush)
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREGS; i++) begin
         if (reset) begin
            r_sb[i] <= 3'd0;
         end else if (w_ld_issue && (w_ld_reg == 5'(i))) begin
            r_sb[i] <= 3'(LOAD_LAT - 1);
         end else if (r_sb[i] != 3'd0) begin
            r_sb[i] <= r_sb[i] - 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Bench for dual_issue_scheduler: directed scenarios plus randomized pairs, all checked
// against a register-mask / ready-cycle reference model.
module tb_dual_issue_scheduler;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1, in_valid = 1'b0, ex_ready = 1'b0, flush = 1'b0;
   logic [31:0] in_pc = '0, in_instr0 = '0, in_instr1 = '0;
   logic        in_ready, iss0_valid, iss1_valid;
   logic [31:0] iss0_instr, iss0_pc, iss1_instr, iss1_pc, stall_cnt, split_cnt;

   logic        b_reset = 1'b1, b_in_valid = 1'b0, b_ex_ready = 1'b0, b_flush = 1'b0;
   logic [31:0] b_in_pc = '0, b_in_instr0 = '0, b_in_instr1 = '0;
   logic        b_in_ready, b_iss0_valid, b_iss1_valid;
   logic [31:0] b_iss0_instr, b_iss0_pc, b_iss1_instr, b_iss1_pc, b_stall_cnt, b_split_cnt;

   always #5 clk = ~clk;

   dual_issue_scheduler #(.LOAD_LAT(LAT), .NREGS(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
      .in_instr0(in_instr0), .in_instr1(in_instr1), .in_ready(in_ready),
      .ex_ready(ex_ready), .flush(flush),
      .iss0_valid(iss0_valid), .iss0_instr(iss0_instr), .iss0_pc(iss0_pc),
      .iss1_valid(iss1_valid), .iss1_instr(iss1_instr), .iss1_pc(iss1_pc),
      .stall_cnt(stall_cnt), .split_cnt(split_cnt));

   dual_issue_scheduler #(.LOAD_LAT(1), .NREGS(32)) dut1 (
      .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_pc(b_in_pc),
      .in_instr0(b_in_instr0), .in_instr1(b_in_instr1), .in_ready(b_in_ready),
      .ex_ready(b_ex_ready), .flush(b_flush),
      .iss0_valid(b_iss0_valid), .iss0_instr(b_iss0_instr), .iss0_pc(b_iss0_pc),
      .iss1_valid(b_iss1_valid), .iss1_instr(b_iss1_instr), .iss1_pc(b_iss1_pc),
      .stall_cnt(b_stall_cnt), .split_cnt(b_split_cnt));

   int checks = 0;
   int failures = 0;

   // reference model: per-register earliest cycle a reader may issue, plus pair progress
   int cyc = 0;
   int ready_at [32];
   bit m_second = 1'b0;
   int m_stall = 0, m_split = 0;

   bit          e_v0, e_v1, e_rdy, e_stall, e_split, e_go_second;
   logic [31:0] e_i0, e_p0, e_i1, e_p1;
   int          e_ld;
   logic        s_v0, s_v1, s_rdy;
   logic [31:0] s_i0, s_p0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // register read/write sets as bitmasks (r0 dropped) and issue-relevant properties
   task automatic info(input logic [31:0] ins, output logic [31:0] rd_m, output logic [31:0] wr_m,
                       output bit mem, output bit ctrl);
      int rs, rt, rd;
      rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
      rd_m = '0; wr_m = '0; mem = 1'b0; ctrl = 1'b0;
      case (ins[31:26])
         6'h00: begin rd_m[rs] = 1'b1; rd_m[rt] = 1'b1; wr_m[rd] = 1'b1; end
         6'h23: begin rd_m[rs] = 1'b1; wr_m[rt] = 1'b1; mem = 1'b1; end
         6'h2B: begin rd_m[rs] = 1'b1; rd_m[rt] = 1'b1; mem = 1'b1; end
         6'h04, 6'h05: begin rd_m[rs] = 1'b1; rd_m[rt] = 1'b1; ctrl = 1'b1; end
         6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D: begin rd_m[rs] = 1'b1; wr_m[rt] = 1'b1; end
         6'h0F: wr_m[rt] = 1'b1;
         6'h02: ctrl = 1'b1;
         6'h03: begin wr_m[31] = 1'b1; ctrl = 1'b1; end
         default: ctrl = 1'b1;
      endcase
      rd_m[0] = 1'b0;
      wr_m[0] = 1'b0;
   endtask

   function automatic bit blocked(input logic [31:0] rd_m);
      for (int r = 1; r < 32; r++)
         if (rd_m[r] && cyc < ready_at[r]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int load_dst(input logic [31:0] ins);
      if (ins[31:26] == 6'h23 && ins[20:16] != 5'd0) return int'(ins[20:16]);
      return -1;
   endfunction

   task automatic model_eval();
      logic [31:0] r0m, w0m, r1m, w1m;
      bit m0, m1, c0, c1;
      e_v0 = 0; e_v1 = 0; e_rdy = 0; e_stall = 0; e_split = 0; e_go_second = 0; e_ld = -1;
      e_i0 = '0; e_p0 = '0; e_i1 = '0; e_p1 = '0;
      info(in_instr0, r0m, w0m, m0, c0);
      info(in_instr1, r1m, w1m, m1, c1);
      if (!reset && !flush && ex_ready) begin
         if (!m_second) begin
            if (in_valid) begin
               if (blocked(r0m)) e_stall = 1;
               else begin
                  e_v0 = 1; e_i0 = in_instr0; e_p0 = in_pc; e_ld = load_dst(in_instr0);
                  if ((r1m & w0m) == 0 && (w1m & w0m) == 0 && !(m0 && m1) && !c0 && !blocked(r1m)) begin
                     e_v1 = 1; e_i1 = in_instr1; e_p1 = in_pc + 4; e_rdy = 1;
                     if (load_dst(in_instr1) > 0) e_ld = load_dst(in_instr1);
                  end else e_go_second = 1;
               end
            end
         end else begin
            if (blocked(r1m)) e_stall = 1;
            else begin
               e_v0 = 1; e_i0 = in_instr1; e_p0 = in_pc + 4; e_rdy = 1; e_split = 1;
               e_ld = load_dst(in_instr1);
            end
         end
      end
   endtask

   task automatic model_commit();
      if (reset) begin
         m_second = 0; m_stall = 0; m_split = 0;
         for (int r = 0; r < 32; r++) ready_at[r] = 0;
      end else begin
         if (e_ld > 0) ready_at[e_ld] = cyc + LAT;
         if (e_stall) m_stall++;
         if (e_split) m_split++;
         if (flush) m_second = 0;
         else if (e_go_second) m_second = 1;
         else if (e_split) m_second = 0;
      end
      cyc++;
   endtask

   // one clock: compare combinational issue at negedge, registered counters after the edge
   task automatic cycle();
      @(negedge clk);
      model_eval();
      s_v0 = iss0_valid; s_v1 = iss1_valid; s_rdy = in_ready; s_i0 = iss0_instr; s_p0 = iss0_pc;
      chk("in_ready", in_ready, e_rdy);
      chk("iss0_valid", iss0_valid, e_v0);
      chk("iss1_valid", iss1_valid, e_v1);
      if (e_v0) begin chk("iss0_instr", iss0_instr, e_i0); chk("iss0_pc", iss0_pc, e_p0); end
      if (e_v1) begin chk("iss1_instr", iss1_instr, e_i1); chk("iss1_pc", iss1_pc, e_p1); end
      @(posedge clk);
      model_commit();
      #1;
      chk("stall_cnt", stall_cnt, 32'(m_stall));
      chk("split_cnt", split_cnt, 32'(m_split));
   endtask

   task automatic setp(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1);
      in_pc = pc; in_instr0 = i0; in_instr1 = i1; in_valid = 1'b1;
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [4:0] rs, rt, rd;
      rs = 5'($urandom_range(0, 4)); rt = 5'($urandom_range(0, 4)); rd = 5'($urandom_range(0, 4));
      case ($urandom_range(0, 9))
         0: return {6'h00, rs, rt, rd, 11'h020};
         1: return {6'h23, rs, rt, 16'h0000};
         2: return {6'h2B, rs, rt, 16'h0004};
         3: return {6'h04, rs, rt, 16'h0002};
         4: return {6'h08, rs, rt, 16'h0011};
         5: return {6'h0F, 5'd0, rt, 16'h1234};
         6: return {6'h02, 26'h0000040};
         7: return {6'h03, 26'h0000080};
         8: return {6'h0D, rs, rt, 16'h00F0};
         default: return {6'h3F, rs, rt, 16'h0000};
      endcase
   endfunction

   initial begin
      for (int r = 0; r < 32; r++) ready_at[r] = 0;

      // reset with a pair presented: nothing may issue
      ex_ready = 1'b1;
      setp(32'h0, 32'h20010005, 32'h20020007);
      cycle(); cycle();
      chk("rst_iss0", {31'd0, s_v0}, 32'd0);
      chk("rst_stall", stall_cnt, 32'd0);
      reset = 1'b0;

      // independent pair
      setp(32'h100, 32'h20010005, 32'h20020007);
      cycle();
      chk("ind_both", {29'd0, s_v0, s_v1, s_rdy}, 32'd7);
      chk("ind_split", split_cnt, 32'd0);

      // RAW pair splits
      setp(32'h200, 32'h20010005, 32'h00211020);
      cycle();
      chk("raw_t0", {29'd0, s_v0, s_v1, s_rdy}, 32'd4);
      cycle();
      chk("raw_t1_instr", s_i0, 32'h00211020);
      chk("raw_t1_pc", s_p0, 32'h204);
      chk("raw_t1_split", split_cnt, 32'd1);

      // load-use
      setp(32'h300, 32'h8C030000, 32'h00000000);
      cycle();
      chk("lw_pair", {30'd0, s_v0, s_v1}, 32'd3);
      setp(32'h308, 32'h00632020, 32'h00000000);
      cycle();
      chk("use_t1_stall", {31'd0, s_v0}, 32'd0);
      chk("use_t1_cnt", stall_cnt, 32'd1);
      cycle();
      chk("use_t2_issue", {31'd0, s_v0}, 32'd1);

      // two stores, then branch in slot0
      setp(32'h400, 32'hAC010000, 32'hAC020004);
      cycle();
      chk("sw_split", {31'd0, s_v1}, 32'd0);
      cycle();
      chk("sw_split_cnt", split_cnt, 32'd2);
      setp(32'h500, 32'h10000002, 32'h00000000);
      cycle();
      chk("beq_split", {30'd0, s_v1, s_rdy}, 32'd0);
      cycle();
      chk("beq_second", {31'd0, s_rdy}, 32'd1);

      // backpressure in S_SECOND
      setp(32'h600, 32'hAC010000, 32'hAC020004);
      cycle();
      ex_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("bp_idle", {31'd0, s_v0}, 32'd0);
      end
      chk("bp_stall", stall_cnt, 32'd1);
      ex_ready = 1'b1;
      cycle();
      chk("bp_release_instr", s_i0, 32'hAC020004);
      chk("bp_release_pc", s_p0, 32'h604);

      // flush in S_SECOND; pending load keeps aging
      setp(32'h700, 32'h8C030000, 32'hAC020004);
      cycle();
      flush = 1'b1;
      cycle();
      chk("flush_idle", {31'd0, s_v0}, 32'd0);
      flush = 1'b0;
      setp(32'h800, 32'h00632020, 32'h00000000);
      cycle();
      chk("flush_next_pc", s_p0, 32'h800);
      chk("flush_sb_aged", {31'd0, s_v0}, 32'd1);

      // reset mid-operation
      setp(32'h900, 32'h8C030000, 32'hAC020004);
      cycle();
      reset = 1'b1;
      cycle();
      chk("rst_mid_out", {29'd0, s_v0, s_v1, s_rdy}, 32'd0);
      chk("rst_mid_split", split_cnt, 32'd0);
      reset = 1'b0;
      setp(32'hA00, 32'h00632020, 32'h00000000);
      cycle();
      chk("rst_mid_pair_pc", s_p0, 32'hA00);

      // randomized pairs, with the front end holding a pair until in_ready
      setp(32'h1000, rnd_instr(), rnd_instr());
      for (int n = 0; n < 400; n++) begin
         ex_ready = ($urandom_range(0, 9) != 0);
         flush = ($urandom_range(0, 24) == 0);
         in_valid = m_second ? 1'b1 : ($urandom_range(0, 7) != 0);
         cycle();
         if (e_rdy || flush || !in_valid) begin
            in_pc = in_pc + 32'd8;
            in_instr0 = rnd_instr();
            in_instr1 = rnd_instr();
         end
      end
      flush = 1'b0;
      in_valid = 1'b0;

      // LOAD_LAT=1 instance: dependent consumer issues on the very next cycle
      @(posedge clk); #1;
      b_reset = 1'b0; b_ex_ready = 1'b1; b_in_valid = 1'b1;
      b_in_pc = 32'h300; b_in_instr0 = 32'h8C030000; b_in_instr1 = 32'h00000000;
      @(negedge clk);
      chk("lat1_lw_pair", {30'd0, b_iss0_valid, b_iss1_valid}, 32'd3);
      @(posedge clk); #1;
      b_in_pc = 32'h308; b_in_instr0 = 32'h00632020;
      @(negedge clk);
      chk("lat1_use_issue", {30'd0, b_iss0_valid, b_in_ready}, 32'd3);
      @(posedge clk); #1;
      chk("lat1_no_stall", b_stall_cnt, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
